// File: rtl/mat_mult_sched.sv
// Time-multiplexed 2x2 matrix product on one shared multiplier-accumulator.
// Define MAT_SCHED_PARALLEL_EN to use two multipliers and a 4-step MAC phase.
module mat_mult_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] A,
  input  logic [4*WIDTH-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        Res,
  output logic               busy,
  output logic [1:0]         o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [4*WIDTH-1:0] r_a;
  logic [4*WIDTH-1:0] r_b;
  logic [15:0]        r_res_el [4];
  logic [WIDTH-1:0]   w_a_el [4];
  logic [WIDTH-1:0]   w_b_el [4];
  logic [1:0]         w_e;
  logic [15:0]        w_sum;
  logic               w_write;

  // Element n of a packed matrix sits at n = 2*row + col, element 0 in the MSBs.
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign w_a_el[g] = r_a[(3-g)*WIDTH +: WIDTH];
    assign w_b_el[g] = r_b[(3-g)*WIDTH +: WIDTH];
  end

`ifdef MAT_SCHED_PARALLEL_EN
  localparam logic [1:0] LAST_STEP = 2'd3;
  logic [1:0]  r_step;
  logic [15:0] w_prod0;
  logic [15:0] w_prod1;

  assign w_e     = r_step;
  assign w_prod0 = 16'(w_a_el[{w_e[1], 1'b0}]) * 16'(w_b_el[{1'b0, w_e[0]}]);
  assign w_prod1 = 16'(w_a_el[{w_e[1], 1'b1}]) * 16'(w_b_el[{1'b1, w_e[0]}]);
  assign w_sum   = w_prod0 + w_prod1;
  assign w_write = 1'b1;
`else
  localparam logic [2:0] LAST_STEP = 3'd7;
  logic [2:0]  r_step;
  logic [15:0] r_acc;
  logic        w_k;
  logic [15:0] w_prod;

  // Step counter packs {e, k}: k toggles fastest so each element finishes in two steps.
  assign w_e     = r_step[2:1];
  assign w_k     = r_step[0];
  assign w_prod  = 16'(w_a_el[{w_e[1], w_k}]) * 16'(w_b_el[{w_k, w_e[0]}]);
  assign w_sum   = (w_k ? r_acc : 16'd0) + w_prod;
  assign w_write = w_k;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_valid/Res are held until out_ready is seen.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
  assign Res         = {r_res_el[0], r_res_el[1], r_res_el[2], r_res_el[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_step  <= '0;
`ifndef MAT_SCHED_PARALLEL_EN
      r_acc   <= '0;
`endif
      for (int n = 0; n < 4; n++) r_res_el[n] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_step  <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_step <= r_step + 1'b1;
`ifndef MAT_SCHED_PARALLEL_EN
          r_acc  <= w_sum;
`endif
          if (w_write) r_res_el[w_e] <= w_sum;
          if (r_step == LAST_STEP) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Directed bench for mat_mult_sched: known values, wrap, back-pressure, reset mid-MAC, back-to-back.
module tb_mat_mult_sched;

  localparam int WIDTH = 8;
`ifdef MAT_SCHED_PARALLEL_EN
  localparam int LAT  = 4;
  localparam int THRU = 6;
`else
  localparam int LAT  = 8;
  localparam int THRU = 10;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  A = '0;
  logic [31:0]  B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  Res;
  logic         busy;
  logic [1:0]   o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  mat_mult_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Res        (Res),
    .busy       (busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  logic [63:0] res_hold;
  int          lat;
  int          pulses;
  int          t_first;
  int          t_second;
  logic [63:0] res_first;
  logic [63:0] res_second;

  initial begin
    // reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res", Res, 64'd0);
    reset = 1'b1;
    tick();

    // known values
    out_ready = 1'b1;
    run_op(32'h01020304, 32'h05060708, lat);
    check("known_latency", 64'(lat), 64'(LAT));
    check("known_out_valid", 64'(out_valid), 64'd1);
    check("known_res", Res, 64'h0013_0016_002B_0032);
    check("known_in_ready_done", 64'(in_ready), 64'd0);
    check("known_busy_done", 64'(busy), 64'd1);
    tick();
    check("known_hs_out_valid", 64'(out_valid), 64'd0);
    check("known_hs_in_ready", 64'(in_ready), 64'd1);
    check("known_res_held", Res, 64'h0013_0016_002B_0032);

    // wrap modulo 2^16
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("wrap_latency", 64'(lat), 64'(LAT));
    check("wrap_res", Res, 64'hFC02_FC02_FC02_FC02);
    tick();

    // back-pressure with noisy in_valid and operands
    out_ready = 1'b0;
    run_op(32'h01010101, 32'h01020304, lat);
    check("bp_latency", 64'(lat), 64'(LAT));
    check("bp_res", Res, 64'h0004_0006_0004_0006);
    res_hold = Res;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      A = $urandom;
      B = $urandom;
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_res_stable", Res, res_hold);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_res", Res, 64'h0004_0006_0004_0006);
    tick();
    check("bp_no_new_op", 64'(busy), 64'd0);

    // reset asserted mid-MAC
    A = 32'h01020304;
    B = 32'h05060708;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midmac_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midmac_rst_out_valid", 64'(out_valid), 64'd0);
    check("midmac_rst_res", Res, 64'd0);
    check("midmac_rst_in_ready", 64'(in_ready), 64'd1);
    check("midmac_rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midmac_after_release_out_valid", 64'(out_valid), 64'd0);
    run_op(32'h01000001, 32'h09080706, lat);
    check("ident_latency", 64'(lat), 64'(LAT));
    check("ident_res", Res, 64'h0009_0008_0007_0006);
    tick();

    // back-to-back with in_valid held high
    out_ready = 1'b1;
    A = 32'h0A0B0C0D;
    B = 32'h01000001;
    in_valid = 1'b1;
    tick();
    A = 32'h02030405;
    B = 32'h01020304;
    pulses = 0;
    t_first = -1;
    t_second = -1;
    res_first = '0;
    res_second = '0;
    for (int c = 1; c <= THRU + LAT + 4; c++) begin
      tick();
      if (c == THRU) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          t_first = c;
          res_first = Res;
        end else if (pulses == 2) begin
          t_second = c;
          res_second = Res;
        end
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first_latency", 64'(t_first), 64'(LAT));
    check("b2b_second_time", 64'(t_second), 64'(THRU + LAT));
    check("b2b_first_res", res_first, 64'h000A_000B_000C_000D);
    check("b2b_second_res", res_second, 64'h000B_0010_0013_001C);
    check("b2b_idle_end", 64'(busy), 64'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
